// File: rtl/card_pkg.sv
// Shared types and constants for the memory-game card grid renderer.
package card_pkg;

    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        SHOWN   = 2'd1,
        MATCHED = 2'd2
    } card_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLOSE = 2'd1,
        OPEN  = 2'd2
    } anim_state_t;

    localparam logic [1:0] OP_FLIP_UP   = 2'd0;
    localparam logic [1:0] OP_FLIP_DOWN = 2'd1;
    localparam logic [1:0] OP_MATCH     = 2'd2;

    localparam logic [2:0] HILITE_RGB = 3'b111;

endpackage

// File: rtl/card_flip_anim.sv
// Flip animator: one card at a time closes to a sliver over FLIP_FRAMES
// frames, swaps its state, then reopens over another FLIP_FRAMES frames.
//
//   state | meaning
//   IDLE  | no animation, commands accepted
//   CLOSE | inset grows by STEP per frame, old face/back shown
//   OPEN  | inset shrinks by STEP per frame, new face/back shown
module card_flip_anim
    import card_pkg::*;
#(
    parameter int CARD_W      = 83,
    parameter int FLIP_FRAMES = 8,
    parameter int IDX_W       = 4,
    parameter int INSET_W     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [IDX_W-1:0]   start_idx,
    output logic [IDX_W-1:0]   active_idx,
    output logic [INSET_W-1:0] inset,
    output anim_state_t        phase,
    output logic               toggle
);

    localparam int STEP  = CARD_W / (2 * FLIP_FRAMES);
    localparam int CNT_W = $clog2(FLIP_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(FLIP_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_TC   = CNT_W'(1);
    localparam logic [INSET_W-1:0] STEP_V   = INSET_W'(STEP);

    anim_state_t        state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [INSET_W-1:0] inset_nxt;
    logic [IDX_W-1:0]   idx_nxt;

    // State, frame down-counter, inset and target card registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            inset      <= '0;
            active_idx <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            inset      <= inset_nxt;
            active_idx <= idx_nxt;
        end
    end

    // Next-state logic; the toggle strobe fires on the last closing frame.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        inset_nxt = inset;
        idx_nxt   = active_idx;
        toggle    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLOSE;
                    cnt_nxt   = CNT_LOAD;
                    inset_nxt = '0;
                    idx_nxt   = start_idx;
                end
            end
            CLOSE: begin
                if (frame_tick) begin
                    inset_nxt = inset + STEP_V;
                    if (cnt == CNT_TC) begin
                        toggle    = 1'b1;
                        state_nxt = OPEN;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            OPEN: begin
                if (frame_tick) begin
                    inset_nxt = inset - STEP_V;
                    if (cnt == CNT_TC) begin
                        state_nxt = IDLE;
                        inset_nxt = '0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                inset_nxt = '0;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: rtl/card_grid_renderer.sv
// Card grid renderer: per-card state/face registers, command decode, and a
// 2-stage pixel pipeline around an external 1-cycle-latency face ROM.
// Optional cursor border: define CARD_GRID_HILITE_EN.
module card_grid_renderer
    import card_pkg::*;
#(
    parameter int         ROWS        = 4,
    parameter int         COLS        = 4,
    parameter int         CARD_W      = 83,
    parameter int         CARD_H      = 83,
    parameter int         PITCH_X     = 100,
    parameter int         PITCH_Y     = 100,
    parameter int         ORG_X       = 130,
    parameter int         ORG_Y       = 70,
    parameter int         FLIP_FRAMES = 8,
    parameter int         FACES       = 8,
    parameter logic [2:0] BACK_RGB    = 3'b001
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [9:0]                                hcount,
    input  logic [9:0]                                vcount,
    input  logic                                      frame_tick,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [1:0]                                cmd_op,
    input  logic [$clog2(ROWS*COLS)-1:0]              cmd_idx,
    input  logic [$clog2(FACES)-1:0]                  cmd_face,
    input  logic [$clog2(ROWS*COLS)-1:0]              cursor_idx,
    output logic [$clog2(FACES)+$clog2(CARD_H)-1:0]   rom_addr,
    input  logic [3*CARD_W-1:0]                       rom_data,
    output logic                                      cardon,
    output logic [2:0]                                rgb,
    output logic                                      busy
);

    localparam int N      = ROWS * COLS;
    localparam int IDX_W  = $clog2(N);
    localparam int FACE_W = $clog2(FACES);
    localparam int ROW_W  = $clog2(CARD_H);
    localparam int CW     = $clog2(CARD_W);

    localparam logic [9:0]       ORG_X_V  = 10'(ORG_X);
    localparam logic [9:0]       ORG_Y_V  = 10'(ORG_Y);
    localparam logic [9:0]       CARD_W_V = 10'(CARD_W);
    localparam logic [9:0]       CARD_H_V = 10'(CARD_H);
    localparam logic [IDX_W:0]   N_V      = (IDX_W + 1)'(N);
    localparam logic [CW-1:0]    LAST_COL = CW'(CARD_W - 1);

    card_state_t        card_st   [N];
    logic [FACE_W-1:0]  card_face [N];

    // ---------------- command decode ----------------
    logic               accept, idx_ok, flip_start, do_match;
    card_state_t        cur_st;
    logic [IDX_W-1:0]   act_idx;
    logic [CW-1:0]      inset;
    anim_state_t        phase;
    logic               toggle;

    assign accept     = cmd_valid && cmd_ready;
    assign idx_ok     = ({1'b0, cmd_idx} < N_V);
    assign cur_st     = idx_ok ? card_st[cmd_idx] : HIDDEN;
    assign flip_start = accept && idx_ok &&
                        (((cmd_op == OP_FLIP_UP)   && (cur_st == HIDDEN)) ||
                         ((cmd_op == OP_FLIP_DOWN) && (cur_st == SHOWN)));
    assign do_match   = accept && idx_ok && (cmd_op == OP_MATCH) && (cur_st == SHOWN);
    assign cmd_ready  = (phase == IDLE);
    assign busy       = (phase != IDLE);

    card_flip_anim #(
        .CARD_W      (CARD_W),
        .FLIP_FRAMES (FLIP_FRAMES),
        .IDX_W       (IDX_W),
        .INSET_W     (CW)
    ) u_anim (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (flip_start),
        .start_idx  (cmd_idx),
        .active_idx (act_idx),
        .inset      (inset),
        .phase      (phase),
        .toggle     (toggle)
    );

    // Per-card state and face registers. Match and toggle never coincide:
    // matches are only accepted in IDLE, toggles only occur in CLOSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                card_st[i]   <= HIDDEN;
                card_face[i] <= '0;
            end
        end else begin
            if (flip_start && (cmd_op == OP_FLIP_UP))
                card_face[cmd_idx] <= cmd_face;
            if (do_match)
                card_st[cmd_idx] <= MATCHED;
            if (toggle)
                card_st[act_idx] <= (card_st[act_idx] == SHOWN) ? HIDDEN : SHOWN;
        end
    end

    // ---------------- pixel stage 1 ----------------
    logic [9:0]       dx, dy, lx, ly;
    int               ci, ri;
    logic             hit_x, hit_y;
    logic [IDX_W-1:0] pix_idx;

    // Grid hit test; card column/row found by comparator chains on the pitch.
    always_comb begin
        dx = hcount - ORG_X_V;
        dy = vcount - ORG_Y_V;
        ci = 0;
        ri = 0;
        lx = dx;
        ly = dy;
        for (int c = 1; c < COLS; c++) begin
            if (dx >= 10'(c * PITCH_X)) begin
                ci = c;
                lx = dx - 10'(c * PITCH_X);
            end
        end
        for (int r = 1; r < ROWS; r++) begin
            if (dy >= 10'(r * PITCH_Y)) begin
                ri = r;
                ly = dy - 10'(r * PITCH_Y);
            end
        end
        // Positions left of/above the origin wrap in dx/dy and must miss.
        hit_x   = (hcount >= ORG_X_V) && (lx < CARD_W_V);
        hit_y   = (vcount >= ORG_Y_V) && (ly < CARD_H_V);
        pix_idx = IDX_W'(ri * COLS + ci);
    end

    assign rom_addr = {card_face[pix_idx], ly[ROW_W-1:0]};

    logic             s1_hit, s1_anim;
    logic [CW-1:0]    s1_col, s1_inset;
    logic [ROW_W-1:0] s1_row;
    card_state_t      s1_state;

    // Stage 1 register: hit, local coordinates and the card's current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit   <= 1'b0;
            s1_anim  <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_inset <= '0;
            s1_state <= HIDDEN;
        end else begin
            s1_hit   <= hit_x && hit_y;
            s1_anim  <= (phase != IDLE) && (pix_idx == act_idx);
            s1_col   <= lx[CW-1:0];
            s1_row   <= ly[ROW_W-1:0];
            s1_inset <= inset;
            s1_state <= card_st[pix_idx];
        end
    end

`ifdef CARD_GRID_HILITE_EN
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CARD_H - 1);
    logic s1_cur;

    // Remember whether this pixel belongs to the cursor card.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_cur <= 1'b0;
        else        s1_cur <= (pix_idx == cursor_idx);
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor_idx;
`endif

    // ---------------- pixel stage 2 ----------------
    logic       masked, on_nxt;
    logic [2:0] rgb_nxt;

    // Colour select: back, ROM face, border, or black in gaps/inset.
    always_comb begin
        masked  = s1_anim && ((s1_col < s1_inset) || (s1_col > (LAST_COL - s1_inset)));
        on_nxt  = s1_hit && !masked;
        rgb_nxt = 3'b000;
        if (on_nxt) begin
            if (s1_state == HIDDEN) rgb_nxt = BACK_RGB;
            else                    rgb_nxt = rom_data[3*int'(s1_col) +: 3];
`ifdef CARD_GRID_HILITE_EN
            if (s1_cur && ((s1_col < CW'(2)) || (s1_col > (LAST_COL - CW'(2))) ||
                           (s1_row < ROW_W'(2)) || (s1_row > (LAST_ROW - ROW_W'(2)))))
                rgb_nxt = HILITE_RGB;
`endif
        end
    end

    // Stage 2 register: the visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cardon <= 1'b0;
            rgb    <= 3'b000;
        end else begin
            cardon <= on_nxt;
            rgb    <= rgb_nxt;
        end
    end

endmodule
